// File: rtl/animation_control.sv
// Control FSM for the animation datapath: sequences the A/B/C/X operand loads
// and the fixed 5-cycle program computing A*X^2 + B*X + C.
module animation_control #(
    parameter int unsigned DONE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_c,
    output logic       ld_x,
    output logic       ld_alu_out,
    output logic       ld_r,
    output logic [1:0] alu_select_1,
    output logic [1:0] alu_select_2,
    output logic       alu_op,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_CYCLES - 1);

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    typedef enum logic [3:0] {
        S_LOAD_A      = 4'd0,
        S_LOAD_A_WAIT = 4'd1,
        S_LOAD_B      = 4'd2,
        S_LOAD_B_WAIT = 4'd3,
        S_LOAD_C      = 4'd4,
        S_LOAD_C_WAIT = 4'd5,
        S_LOAD_X      = 4'd6,
        S_LOAD_X_WAIT = 4'd7,
        S_CYC0        = 4'd8,
        S_CYC1        = 4'd9,
        S_CYC2        = 4'd10,
        S_CYC3        = 4'd11,
        S_CYC4        = 4'd12,
        S_DONE        = 4'd13
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic       ld_a_nxt;
    logic       ld_b_nxt;
    logic       ld_c_nxt;
    logic       ld_x_nxt;
    logic       ld_alu_out_nxt;
    logic       ld_r_nxt;
    logic [1:0] sel1_nxt;
    logic [1:0] sel2_nxt;
    logic       alu_op_nxt;
    logic       busy_nxt;
    logic       done_nxt;

    // Outputs are the Moore decode of the state, registered alongside it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_LOAD_A;
            cnt          <= '0;
            ld_a         <= 1'b0;
            ld_b         <= 1'b0;
            ld_c         <= 1'b0;
            ld_x         <= 1'b0;
            ld_alu_out   <= 1'b0;
            ld_r         <= 1'b0;
            alu_select_1 <= 2'd0;
            alu_select_2 <= 2'd0;
            alu_op       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            ld_a         <= ld_a_nxt;
            ld_b         <= ld_b_nxt;
            ld_c         <= ld_c_nxt;
            ld_x         <= ld_x_nxt;
            ld_alu_out   <= ld_alu_out_nxt;
            ld_r         <= ld_r_nxt;
            alu_select_1 <= sel1_nxt;
            alu_select_2 <= sel2_nxt;
            alu_op       <= alu_op_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        ld_a_nxt       = 1'b0;
        ld_b_nxt       = 1'b0;
        ld_c_nxt       = 1'b0;
        ld_x_nxt       = 1'b0;
        ld_alu_out_nxt = 1'b0;
        ld_r_nxt       = 1'b0;
        sel1_nxt       = 2'd0;
        sel2_nxt       = 2'd0;
        alu_op_nxt     = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            S_LOAD_A:      if (go)  state_next = S_LOAD_A_WAIT;
            S_LOAD_A_WAIT: if (!go) state_next = S_LOAD_B;
            S_LOAD_B:      if (go)  state_next = S_LOAD_B_WAIT;
            S_LOAD_B_WAIT: if (!go) state_next = S_LOAD_C;
            S_LOAD_C:      if (go)  state_next = S_LOAD_C_WAIT;
            S_LOAD_C_WAIT: if (!go) state_next = S_LOAD_X;
            S_LOAD_X:      if (go)  state_next = S_LOAD_X_WAIT;
            S_LOAD_X_WAIT: if (!go) state_next = S_CYC0;
            S_CYC0:        state_next = S_CYC1;
            S_CYC1:        state_next = S_CYC2;
            S_CYC2:        state_next = S_CYC3;
            S_CYC3:        state_next = S_CYC4;
            S_CYC4: begin
                state_next = S_DONE;
                cnt_next   = '0;
            end
            S_DONE: begin
                if (cnt == DONE_LAST) begin
                    state_next = S_LOAD_A;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_LOAD_A;
                cnt_next   = '0;
            end
        endcase

        // Datapath program: a<=a*x, a<=a*x, b<=b*x, a<=a+b, r<=a+c.
        case (state_next)
            S_LOAD_A_WAIT: ld_a_nxt = 1'b1;
            S_LOAD_B_WAIT: ld_b_nxt = 1'b1;
            S_LOAD_C_WAIT: ld_c_nxt = 1'b1;
            S_LOAD_X_WAIT: ld_x_nxt = 1'b1;
            S_CYC0, S_CYC1: begin
                ld_a_nxt       = 1'b1;
                ld_alu_out_nxt = 1'b1;
                sel1_nxt       = SEL_A;
                sel2_nxt       = SEL_X;
                alu_op_nxt     = 1'b1;
                busy_nxt       = 1'b1;
            end
            S_CYC2: begin
                ld_b_nxt       = 1'b1;
                ld_alu_out_nxt = 1'b1;
                sel1_nxt       = SEL_B;
                sel2_nxt       = SEL_X;
                alu_op_nxt     = 1'b1;
                busy_nxt       = 1'b1;
            end
            S_CYC3: begin
                ld_a_nxt       = 1'b1;
                ld_alu_out_nxt = 1'b1;
                sel1_nxt       = SEL_A;
                sel2_nxt       = SEL_B;
                busy_nxt       = 1'b1;
            end
            S_CYC4: begin
                ld_r_nxt = 1'b1;
                sel1_nxt = SEL_A;
                sel2_nxt = SEL_C;
                busy_nxt = 1'b1;
            end
            S_DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_animation_control.sv
// Bench for animation_control: drives go/resetn, runs a behavioural datapath
// off the control outputs and checks every cycle against a protocol model.
module tb_animation_control;

    localparam int unsigned DC = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic       ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r;
    logic [1:0] alu_select_1, alu_select_2;
    logic       alu_op, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    animation_control #(.DONE_CYCLES(DC)) dut (
        .clk(clk), .resetn(resetn), .go(go),
        .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x),
        .ld_alu_out(ld_alu_out), .ld_r(ld_r),
        .alu_select_1(alu_select_1), .alu_select_2(alu_select_2),
        .alu_op(alu_op), .busy(busy), .done(done)
    );

    // Behavioural datapath driven by the controller.
    logic [7:0] data_in;
    logic [7:0] ra, rb, rc, rx, rr;
    logic [7:0] opa, opb, alu;

    always_comb begin
        case (alu_select_1)
            2'd0: opa = ra;
            2'd1: opa = rb;
            2'd2: opa = rc;
            default: opa = rx;
        endcase
        case (alu_select_2)
            2'd0: opb = ra;
            2'd1: opb = rb;
            2'd2: opb = rc;
            default: opb = rx;
        endcase
        alu = alu_op ? 8'(opa * opb) : 8'(opa + opb);
    end

    always @(posedge clk) begin
        if (ld_a) ra <= ld_alu_out ? alu : data_in;
        if (ld_b) rb <= ld_alu_out ? alu : data_in;
        if (ld_c) rc <= ld_alu_out ? alu : data_in;
        if (ld_x) rx <= ld_alu_out ? alu : data_in;
        if (ld_r) rr <= alu;
    end

    // Protocol model: phase 0 load-idle, 1 load-wait, 2 compute, 3 done.
    int m_phase = 0, m_idx = 0, m_step = 0, m_dcnt = 0;

    task automatic model_step();
        if (!resetn) begin
            m_phase = 0;
            m_idx   = 0;
        end else begin
            case (m_phase)
                0: if (go) m_phase = 1;
                1: if (!go) begin
                    if (m_idx == 3) begin
                        m_phase = 2;
                        m_step  = 0;
                    end else begin
                        m_idx++;
                        m_phase = 0;
                    end
                end
                2: if (m_step == 4) begin
                    m_phase = 3;
                    m_dcnt  = 0;
                end else m_step++;
                default: if (m_dcnt == int'(DC) - 1) begin
                    m_phase = 0;
                    m_idx   = 0;
                end else m_dcnt++;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // {ld_a,ld_b,ld_c,ld_x,ld_alu_out,ld_r,sel1,sel2,op,busy,done}
    function automatic logic [12:0] exp_vec();
        logic [12:0] v;
        v = '0;
        if (m_phase == 1) v[12 - m_idx] = 1'b1;
        if (m_phase == 2) begin
            case (m_step)
                0, 1:    v = 13'b1_000_1_0_00_11_1_1_0;
                2:       v = 13'b0_100_1_0_01_11_1_1_0;
                3:       v = 13'b1_000_1_0_00_01_0_1_0;
                default: v = 13'b0_000_0_1_00_10_0_1_0;
            endcase
        end
        if (m_phase == 3) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [12:0] obs_vec();
        return {ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r,
                alu_select_1, alu_select_2, alu_op, busy, done};
    endfunction

    // Full load + compute; optional reset abort at a compute step and go held through DONE.
    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] vc, input logic [7:0] vx, input int hi_b,
                          input bit toggle, input int abort_at, input bit go_in_done);
        logic [7:0] vals [4];
        int hi, expr, n_busy, n_done, n_ldr;
        vals   = '{va, vb, vc, vx};
        expr   = (int'(va) * int'(vx) * int'(vx) + int'(vb) * int'(vx) + int'(vc)) % 256;
        n_busy = 0;
        n_done = 0;
        n_ldr  = 0;
        for (int r = 0; r < 4; r++) begin
            hi = (r == 1) ? hi_b : 3;
            go = 1'b1;
            for (int k = 0; k < hi; k++) begin
                data_in = 8'($urandom);
                tick();
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL %s load%0d_hold: got %b expected %b", name, r, obs_vec(), exp_vec());
                end
            end
            go = 1'b0;
            data_in = vals[r];
            tick();
            n_busy += int'(busy);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL %s load%0d_release: got %b expected %b", name, r, obs_vec(), exp_vec());
            end
            if (r < 3) begin
                data_in = 8'($urandom);
                tick();
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL %s load%0d_idle: got %b expected %b", name, r, obs_vec(), exp_vec());
                end
            end
        end
        for (int k = 0; k < 5 + int'(DC); k++) begin
            data_in = 8'($urandom);
            if (m_phase == 2 && toggle) go = 1'($urandom);
            else if (m_phase == 3 && go_in_done) go = 1'b1;
            else go = 1'b0;
            if (abort_at >= 0 && m_phase == 2 && m_step == abort_at) resetn = 1'b0;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL %s compute_c%0d: got %b expected %b", name, k, obs_vec(), exp_vec());
            end
            if (!resetn) begin
                n_cmp++;
                if (obs_vec() !== 13'd0) begin
                    n_err++;
                    $display("FAIL %s abort_outputs: got %b expected 0", name, obs_vec());
                end
                resetn = 1'b1;
            end
            n_busy += int'(busy);
            n_done += int'(done);
            n_ldr  += int'(ld_r);
            if (m_phase == 3 && m_dcnt == 0) begin
                n_cmp++;
                if (int'(rr) !== expr || done !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s result: got %0d done=%b expected %0d done=1", name, rr, done, expr);
                end
            end
        end
        n_cmp++;
        if (n_busy !== ((abort_at >= 0) ? abort_at + 1 : 5)) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d", name, n_busy);
        end
        n_cmp++;
        if (n_done !== ((abort_at >= 0) ? 0 : int'(DC)) || n_ldr !== ((abort_at >= 0) ? 0 : 1)) begin
            n_err++;
            $display("FAIL %s done_ldr_counts: got done=%0d ld_r=%0d", name, n_done, n_ldr);
        end
        if (go_in_done) begin
            tick();
            n_cmp++;
            if (ld_a !== 1'b1 || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL %s go_through_done: got %b expected %b", name, obs_vec(), exp_vec());
            end
            go = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        go = 1'b0;
        data_in = 8'd0;
        repeat (2) begin
            tick();
            n_cmp++;
            if (obs_vec() !== 13'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b expected 0", obs_vec());
            end
        end
        resetn = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (obs_vec() !== 13'd0 || exp_vec() !== 13'd0) begin
                n_err++;
                $display("FAIL reset_idle: got %b expected 0", obs_vec());
            end
        end
    endtask

    task automatic test_nominal();
        run_op("nominal", 8'd2, 8'd3, 8'd4, 8'd5, 3, 1'b0, -1, 1'b0);
        n_cmp++;
        if (rr !== 8'd69) begin
            n_err++;
            $display("FAIL nominal_69: got %0d expected 69", rr);
        end
    endtask

    task automatic test_wrap();
        run_op("wrap1000", 8'd10, 8'd0, 8'd0, 8'd10, 3, 1'b0, -1, 1'b0);
        n_cmp++;
        if (rr !== 8'd232) begin
            n_err++;
            $display("FAIL wrap_232: got %0d expected 232", rr);
        end
        run_op("const_c", 8'd0, 8'd0, 8'd7, 8'd0, 3, 1'b0, -1, 1'b0);
        n_cmp++;
        if (rr !== 8'd7) begin
            n_err++;
            $display("FAIL const_7: got %0d expected 7", rr);
        end
    endtask

    task automatic test_handshake();
        run_op("handshake", 8'd2, 8'd3, 8'd4, 8'd5, 20, 1'b1, -1, 1'b0);
        n_cmp++;
        if (rr !== 8'd69) begin
            n_err++;
            $display("FAIL handshake_69: got %0d expected 69", rr);
        end
    endtask

    task automatic test_reset_mid();
        run_op("abort_cyc2", 8'd9, 8'd8, 8'd7, 8'd6, 3, 1'b0, 2, 1'b0);
        run_op("after_abort", 8'd2, 8'd3, 8'd4, 8'd5, 3, 1'b0, -1, 1'b0);
        n_cmp++;
        if (rr !== 8'd69) begin
            n_err++;
            $display("FAIL after_abort_69: got %0d expected 69", rr);
        end
    endtask

    task automatic test_done_width();
        run_op("done_width", 8'd1, 8'd1, 8'd1, 8'd1, 3, 1'b0, -1, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (obs_vec() !== 13'd0) begin
            n_err++;
            $display("FAIL done_width_realign: got %b expected 0", obs_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 6)), 1'($urandom), -1, 1'b0);
        end
    endtask

    initial begin
        resetn = 1'b0;
        go = 1'b0;
        data_in = 8'd0;
        test_reset();
        test_nominal();
        test_wrap();
        test_handshake();
        test_reset_mid();
        test_done_width();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
